// File: rtl/ift_mon_pkg.sv
// Shared types and helpers for the IFT taint monitor (ift_taint_monitor and ift_mon_chan).
package ift_mon_pkg;

    localparam int TW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MON   = 2'd1,
        ST_ALERT = 2'd2
    } state_e;

    // LSB position of channel ch's label within the flattened taint bus
    function automatic int lbl_lo(input int ch, input int tw);
        return ch * tw;
    endfunction

endpackage

// File: rtl/ift_mon_chan.sv
// One monitored channel: sticky OR of labels, saturating tainted-sample counter, policy hit flag.
module ift_mon_chan
    import ift_mon_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    input  logic          enable,
    input  logic          clear,
    input  logic [TW-1:0] label,
    input  logic [TW-1:0] pol_mask,
    output logic [TW-1:0] sticky,
    output logic [CW-1:0] cnt,
    output logic          viol
);

    logic [TW-1:0] sticky_q, sticky_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clear) begin
            sticky_d = '0;
            cnt_d    = '0;
        end else if (valid && enable) begin
            sticky_d = sticky_q | label;
            if ((|label) && (cnt_q != {CW{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky = sticky_q;
    assign cnt    = cnt_q;
    assign viol   = valid && (|(label & pol_mask));

endmodule

// File: rtl/ift_taint_monitor.sv
// Taint monitor: per-channel accumulation plus FSM, lowest-index priority encoder and alert capture.
// Optional IFT_MON_TIMESTAMP_EN adds a cycle counter with alert_time / alert_data capture.
module ift_taint_monitor
    import ift_mon_pkg::*;
#(
    parameter int NCH = 8,
    parameter int TW  = TW_DEF,
    parameter int CW  = 8,
    parameter int CHW = 3,
    parameter int TSW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              clear,
    input  logic [TW-1:0]     pol_mask,
    input  logic              smp_valid,
    input  logic [NCH-1:0]    smp_data,
    input  logic [NCH*TW-1:0] smp_taint,
    output logic              alert,
    output logic [CHW-1:0]    alert_ch,
    output logic [TW-1:0]     alert_label,
    input  logic              alert_ack,
    output logic              alert_miss,
    output logic [NCH*TW-1:0] sticky_taint,
    output logic [NCH*CW-1:0] taint_cnt,
`ifdef IFT_MON_TIMESTAMP_EN
    output logic [TSW-1:0]    alert_time,
    output logic              alert_data,
`endif
    output logic [1:0]        state_o
);

    state_e         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [TW-1:0]  label_q, label_d;
    logic           miss_q, miss_d;
    logic [NCH-1:0] viol;
    logic           hit_any;
    logic [CHW-1:0] hit_ch;
    logic [TW-1:0]  hit_label;
    logic           capture;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        localparam int LO = lbl_lo(i, TW);
        ift_mon_chan #(.TW(TW), .CW(CW)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid    (smp_valid),
            .enable   (state_q != ST_IDLE),
            .clear    (clear),
            .label    (smp_taint[LO +: TW]),
            .pol_mask (pol_mask),
            .sticky   (sticky_taint[LO +: TW]),
            .cnt      (taint_cnt[i*CW +: CW]),
            .viol     (viol[i])
        );
    end

    // Descending scan so the lowest violating index is the one left standing
    always_comb begin
        hit_any = 1'b0;
        hit_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (viol[i]) begin
                hit_any = 1'b1;
                hit_ch  = CHW'(i);
            end
        end
        hit_label = smp_taint[hit_ch*TW +: TW] & pol_mask;
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        label_d = label_q;
        miss_d  = miss_q;
        capture = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            ch_d    = '0;
            label_d = '0;
            miss_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (arm) state_d = ST_MON;
                ST_MON: begin
                    if (hit_any) begin
                        state_d = ST_ALERT;
                        ch_d    = hit_ch;
                        label_d = hit_label;
                        capture = 1'b1;
                    end
                end
                ST_ALERT: begin
                    // A violation racing the ack is reported as a miss, never a fresh alert
                    if (hit_any)   miss_d  = 1'b1;
                    if (alert_ack) state_d = ST_MON;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            label_q <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            label_q <= label_d;
            miss_q  <= miss_d;
        end
    end

    assign alert       = (state_q == ST_ALERT);
    assign alert_ch    = ch_q;
    assign alert_label = label_q;
    assign alert_miss  = miss_q;
    assign state_o     = state_q;

`ifdef IFT_MON_TIMESTAMP_EN
    logic [TSW-1:0] ts_q, ts_d;
    logic [TSW-1:0] time_q, time_d;
    logic           data_q, data_d;

    // Captured time is the counter value as of the capturing edge, i.e. cycles since arm
    always_comb begin
        ts_d   = ts_q;
        time_d = time_q;
        data_d = data_q;
        if (clear) begin
            ts_d   = '0;
            time_d = '0;
            data_d = 1'b0;
        end else begin
            if (state_q != ST_IDLE) ts_d = ts_q + 1'b1;
            if (capture) begin
                time_d = ts_d;
                data_d = smp_data[hit_ch];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            time_q <= '0;
            data_q <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            time_q <= time_d;
            data_q <= data_d;
        end
    end

    assign alert_time = time_q;
    assign alert_data = data_q;
`else
    logic unused_data;
    assign unused_data = ^{smp_data, capture};
`endif

endmodule

// File: tb/tb_ift_taint_monitor.sv
// Self-checking bench for ift_taint_monitor: vector table with scoreboard queue plus hand sequences.
module tb_ift_taint_monitor;

    localparam int NCH = 8;
    localparam int TW  = 32;
    localparam int CW  = 8;
    localparam int CHW = 3;
    localparam int TSW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0, clear = 1'b0, smp_valid = 1'b0, alert_ack = 1'b0;
    logic [TW-1:0]     pol_mask = '0;
    logic [NCH-1:0]    smp_data = '0;
    logic [NCH*TW-1:0] smp_taint = '0;
    logic              alert, alert_miss;
    logic [CHW-1:0]    alert_ch;
    logic [TW-1:0]     alert_label;
    logic [NCH*TW-1:0] sticky_taint;
    logic [NCH*CW-1:0] taint_cnt;
    logic [1:0]        state_o;
`ifdef IFT_MON_TIMESTAMP_EN
    logic [TSW-1:0]    alert_time;
    logic              alert_data;
`endif

    ift_taint_monitor #(.NCH(NCH), .TW(TW), .CW(CW), .CHW(CHW), .TSW(TSW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .clear        (clear),
        .pol_mask     (pol_mask),
        .smp_valid    (smp_valid),
        .smp_data     (smp_data),
        .smp_taint    (smp_taint),
        .alert        (alert),
        .alert_ch     (alert_ch),
        .alert_label  (alert_label),
        .alert_ack    (alert_ack),
        .alert_miss   (alert_miss),
        .sticky_taint (sticky_taint),
        .taint_cnt    (taint_cnt),
`ifdef IFT_MON_TIMESTAMP_EN
        .alert_time   (alert_time),
        .alert_data   (alert_data),
`endif
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              arm, clr, vld, ack;
        logic [TW-1:0]     pol;
        logic [NCH*TW-1:0] taint;
        logic [1:0]        st;
        logic              al;
        logic [CHW-1:0]    ch;
        logic [TW-1:0]     lbl;
        logic              miss;
        logic [CW-1:0]     cnt2;
        logic [TW-1:0]     sticky2;
    } vec_t;

    vec_t tbl[11];
    vec_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [NCH*TW-1:0] mk(input int ca, input logic [TW-1:0] va,
                                             input int cb, input logic [TW-1:0] vb);
        logic [NCH*TW-1:0] t;
        t = '0;
        if (ca >= 0) t[ca*TW +: TW] = va;
        if (cb >= 0) t[cb*TW +: TW] = vb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic c, input logic v, input logic k,
                         input logic [TW-1:0] p, input logic [NCH*TW-1:0] t);
        @(negedge clk);
        arm = a; clear = c; smp_valid = v; alert_ack = k; pol_mask = p; smp_taint = t;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t e;
        //          arm clr vld ack pol     taint                  st al ch lbl  miss cnt2 stk2
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, mk(-1, 0, -1, 0),    2'd1, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4, mk(2, 32'h5, -1, 0), 2'd2, 1'b1, 3'd2, 32'h4, 1'b0, 8'd1, 32'h5};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4, mk(3, 32'hC, -1, 0), 2'd2, 1'b1, 3'd2, 32'h4, 1'b1, 8'd1, 32'h5};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h4, mk(-1, 0, -1, 0),    2'd1, 1'b0, 3'd2, 32'h4, 1'b1, 8'd1, 32'h5};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4, mk(5, 32'h4, 3, 32'hC), 2'd2, 1'b1, 3'd3, 32'h4, 1'b1, 8'd1, 32'h5};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4, mk(1, 32'h4, -1, 0), 2'd1, 1'b0, 3'd3, 32'h4, 1'b1, 8'd1, 32'h5};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(0, 32'hFF, -1, 0), 2'd1, 1'b0, 3'd3, 32'h4, 1'b1, 8'd1, 32'h5};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, mk(2, 32'h1, -1, 0), 2'd1, 1'b0, 3'd3, 32'h4, 1'b1, 8'd2, 32'h5};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4, mk(2, 32'h4, -1, 0), 2'd2, 1'b1, 3'd2, 32'h4, 1'b1, 8'd3, 32'h5};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4, mk(2, 32'h4, -1, 0), 2'd0, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h4, mk(2, 32'h5, -1, 0), 2'd0, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0, 32'h0};

        #12;
        chk("reset_state", 64'(state_o), 64'd0);
        chk("reset_alert", 64'(alert), 64'd0);
        chk("reset_miss", 64'(alert_miss), 64'd0);
        chk("reset_cnt", 64'(|taint_cnt), 64'd0);
        chk("reset_sticky", 64'(|sticky_taint), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].arm, tbl[k].clr, tbl[k].vld, tbl[k].ack, tbl[k].pol, tbl[k].taint);
            sb_q.push_back(tbl[k]);
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d_state", k), 64'(state_o), 64'(e.st));
                chk($sformatf("v%0d_alert", k), 64'(alert), 64'(e.al));
                chk($sformatf("v%0d_ch", k), 64'(alert_ch), 64'(e.ch));
                chk($sformatf("v%0d_label", k), 64'(alert_label), 64'(e.lbl));
                chk($sformatf("v%0d_miss", k), 64'(alert_miss), 64'(e.miss));
                chk($sformatf("v%0d_cnt2", k), 64'(taint_cnt[2*CW +: CW]), 64'(e.cnt2));
                chk($sformatf("v%0d_sticky2", k), 64'(sticky_taint[2*TW +: TW]), 64'(e.sticky2));
            end
        end
        chk("idle_all_cnt", 64'(|taint_cnt), 64'd0);
        chk("idle_all_sticky", 64'(|sticky_taint), 64'd0);

        // Saturation: 300 tainted samples on ch0 with an empty policy
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(0, 32'h1, -1, 0));
            @(posedge clk); #1;
        end
        chk("sat_cnt0", 64'(taint_cnt[0 +: CW]), 64'd255);
        chk("sat_no_alert", 64'(alert), 64'd0);
        chk("sat_state", 64'(state_o), 64'd1);
        chk("sat_sticky0", 64'(sticky_taint[0 +: TW]), 64'h1);

        // Async reset in ALERT clears without an edge
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, mk(0, 32'h1, -1, 0));
        @(posedge clk); #1;
        chk("pre_rst_alert", 64'(alert), 64'd1);
        idle_cycle();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_alert", 64'(alert), 64'd0);
        chk("async_rst_state", 64'(state_o), 64'd0);
        chk("async_rst_cnt", 64'(|taint_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IFT_MON_TIMESTAMP_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        for (int n = 0; n < 9; n++) idle_cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h2, mk(4, 32'h2, -1, 0));
        smp_data = 8'h10;
        @(posedge clk); #1;
        chk("ts_alert", 64'(alert), 64'd1);
        chk("ts_time", 64'(alert_time), 64'd10);
        chk("ts_data", 64'(alert_data), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ift_taint_monitor.md
Name: ift_taint_monitor

Overview:
- Sequential checker placed directly downstream of the IFT-instrumented unary-gate block.
- Each cycle it samples NCH 1-bit outputs and their TW-bit taint labels (the *_out / *_out_t pairs).
- Keeps per-channel sticky taint and saturating counts of tainted samples.
- Raises a handshaked alert when any label hits a forbidden-label policy mask.

Parameters:
NCH, 8, number of monitored channels (not, pos, neg, reduce_and/or/xor/xnor, logic_not)
TW, 32, taint label width per channel
CW, 8, per-channel tainted-sample counter width
CHW, 3, channel index width, must satisfy 2**CHW >= NCH
TSW, 16, timestamp width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  start monitoring (pulse)
clear  in  1  synchronous clear of all state (pulse)
pol_mask  in  TW  forbidden label bits
smp_valid  in  1  sample qualifier
smp_data  in  NCH  channel data bits, ch0 at LSB
smp_taint  in  NCH*TW  labels, ch i at [i*TW +: TW]
alert  out  1  policy violation pending
alert_ch  out  CHW  violating channel index
alert_label  out  TW  smp_taint[ch] & pol_mask at capture
alert_ack  in  1  consumer acknowledge
alert_miss  out  1  sticky: violation seen while alert pending
sticky_taint  out  NCH*TW  OR-accumulated labels per channel
taint_cnt  out  NCH*CW  tainted-sample count per channel
state_o  out  2  0=IDLE 1=MON 2=ALERT

Behaviour:
- Reset (rst_n low, async): state IDLE. alert, alert_ch, alert_label, alert_miss, sticky_taint and taint_cnt all zero.
- IDLE: samples ignored. arm -> MON on the next edge.
- MON: on smp_valid, per channel i:
  - sticky_taint[i] |= smp_taint[i].
  - If smp_taint[i] != 0, taint_cnt[i] += 1, saturating at 2**CW-1 (no wrap).
  - If any (smp_taint[i] & pol_mask) != 0: go to ALERT. alert_ch = lowest violating index, alert_label = that channel's masked label. All registered, 1-cycle latency.
  - pol_mask == 0: never alerts.
- ALERT:
  - alert = 1.
  - Accumulation and counting continue.
  - A new violating valid sample sets alert_miss; alert_ch and alert_label hold.
  - alert_ack -> MON next edge, alert drops.
  - Ack together with a violating sample: that sample sets alert_miss, not a new alert.
- alert_miss clears only on clear or reset.
- clear (any state): next edge gives IDLE with all outputs zeroed. clear has priority over arm, alert_ack and samples.
- arm in MON or ALERT: ignored.
- smp_data is not used in the decision logic. It only feeds the optional feature.
- Reset mid-ALERT: everything zero immediately, no ack needed.

Optional Feature:
Macro IFT_MON_TIMESTAMP_EN.
- Defined:
  - Adds a free-running TSW-bit cycle counter. It is zeroed at reset or clear, counts only while not IDLE, and wraps.
  - Adds output alert_time (TSW). It captures the counter value at alert capture and holds it until the next alert.
  - Adds output alert_data (1). It captures smp_data[alert_ch].
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package ift_mon_pkg: state enum (IDLE/MON/ALERT, 2 bits), default TW=32, label-slice helper function.
- Sub-module ift_mon_chan, instantiated NCH times:
  - Per-channel sticky OR, saturating counter, violation flag.
  - Inputs: valid, enable, clear, label, pol_mask.
  - Outputs: sticky, cnt, viol.
- The top holds the FSM, the priority encoder and the alert capture.

Test Plan:
- Reset then arm, NCH=8, pol_mask=0x0000_0004:
  - Stimulus: valid sample with ch2 label 0x5 and other channels 0.
  - Required: next cycle alert=1, alert_ch=2, alert_label=0x4, taint_cnt[2]=1, sticky_taint[2]=0x5.
- Multi-channel violation:
  - Stimulus: ch5 label 0x4 and ch3 label 0xC in the same sample.
  - Required: alert_ch=3, alert_label=0x4.
- Missed violation and ack:
  - Stimulus: violating sample while in ALERT, then alert_ack.
  - Required: alert_miss=1, alert_ch unchanged; next cycle state MON and alert=0.
- Counter saturation, CW=8:
  - Stimulus: 300 valid samples with ch0 label 0x1 and pol_mask=0.
  - Required: taint_cnt[0]=255, no alert.
- Clear priority:
  - Stimulus: clear, arm and alert_ack together while in ALERT.
  - Required: IDLE, all outputs 0, and a subsequent tainted sample is ignored.
- Async reset and timestamp (with IFT_MON_TIMESTAMP_EN):
  - Stimulus: arm; violation 10 cycles after arm.
  - Required: alert_time=10.
  - Stimulus: rst_n asserted mid-cycle.
  - Required: alert falls without waiting for a clock edge.
